// File: rtl/hzd_pkg.sv
// Shared types for the ID-stage hazard unit: in-flight destination slots
// and the producer test used by stall and forwarding logic.
package hzd_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] X0 = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } slot_t;

  function automatic logic is_producer(input slot_t s);
    return s.valid && s.wen && (s.rd != X0);
  endfunction

endpackage

// File: rtl/hzd_fsel.sv
// Per-operand forwarding select. The one-hot output is ordered as
// {mem, mem_alu, alu}, and the nearest producer takes priority.
module hzd_fsel
  import hzd_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  slot_t             ex,
  input  slot_t             mem,
  output logic [2:0]        sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = is_producer(ex) && (ex.rd == rs);
  assign mem_hit = is_producer(mem) && (mem.rd == rs);

  // An EX load that matches shadows any older MEM match. Load-use then
  // bubbles the consumer, so the select it produces is discarded.
  always_comb begin
    sel = 3'b000;
    if (use_rs && (rs != X0)) begin
      if (ex_hit)
        sel = ex.load ? 3'b000 : 3'b001;
      else if (mem_hit)
        sel = mem.load ? 3'b100 : 3'b010;
    end
  end

endmodule

// File: rtl/hzd_unit.sv
// ID-stage hazard detection: load-use stall, redirect flush, memory freeze,
// registered forwarding selects for EX, and a load-use stall counter.
module hzd_unit #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_wen,
  input  logic              i_id_mem_read,
  input  logic              i_ex_redirect,
  input  logic              i_mem_busy,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_flush_id,
  output logic              o_bubble_ex,
  output logic              o_frwd_alu_op1,
  output logic              o_frwd_mem_alu_op1,
  output logic              o_frwd_mem_op1,
  output logic              o_frwd_alu_op2,
  output logic              o_frwd_mem_alu_op2,
  output logic              o_frwd_mem_op2,
  output logic [CNT_W-1:0]  o_stall_cnt
);
  import hzd_pkg::*;

  slot_t            ex_q, mem_q, wb_q;
  slot_t            id_slot;
  logic             lu;
  logic [2:0]       sel1, sel2;
  logic [2:0]       frwd1_q, frwd2_q;
  logic [CNT_W-1:0] cnt_q;

  assign id_slot = '{valid: i_id_valid, rd: i_id_rd, wen: i_id_reg_wen, load: i_id_mem_read};

  assign lu = i_id_valid && is_producer(ex_q) && ex_q.load &&
              ((i_id_use_rs1 && (i_id_rs1 == ex_q.rd)) ||
               (i_id_use_rs2 && (i_id_rs2 == ex_q.rd)));

  hzd_fsel u_fsel_op1 (
    .rs     (i_id_rs1),
    .use_rs (i_id_use_rs1),
    .ex     (ex_q),
    .mem    (mem_q),
    .sel    (sel1)
  );

  hzd_fsel u_fsel_op2 (
    .rs     (i_id_rs2),
    .use_rs (i_id_use_rs2),
    .ex     (ex_q),
    .mem    (mem_q),
    .sel    (sel2)
  );

  // Reset forces the controls low even while a freeze is being requested.
  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_flush_id  = 1'b0;
    o_bubble_ex = 1'b0;
    if (i_rst) begin
      o_stall_if = 1'b0;
    end else if (i_mem_busy) begin
      o_stall_if = 1'b1;
      o_stall_id = 1'b1;
    end else if (i_ex_redirect) begin
      o_flush_id  = 1'b1;
      o_bubble_ex = 1'b1;
    end else if (lu) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      frwd1_q <= 3'b000;
      frwd2_q <= 3'b000;
      cnt_q   <= '0;
    end else if (!i_mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (o_bubble_ex) begin
        ex_q    <= '0;
        frwd1_q <= 3'b000;
        frwd2_q <= 3'b000;
      end else begin
        ex_q    <= id_slot;
        frwd1_q <= sel1;
        frwd2_q <= sel2;
      end
      if (lu && !i_ex_redirect)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_frwd_alu_op1     = frwd1_q[0];
  assign o_frwd_mem_alu_op1 = frwd1_q[1];
  assign o_frwd_mem_op1     = frwd1_q[2];
  assign o_frwd_alu_op2     = frwd2_q[0];
  assign o_frwd_mem_alu_op2 = frwd2_q[1];
  assign o_frwd_mem_op2     = frwd2_q[2];
  assign o_stall_cnt        = cnt_q;

endmodule

// File: tb/tb_hzd_unit.sv
// Directed bench for hzd_unit: hand-computed control, forwarding and
// counter values along a linear instruction sequence.
module tb_hzd_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_id_valid = 1'b0;
  logic [4:0]  i_id_rs1 = '0;
  logic [4:0]  i_id_rs2 = '0;
  logic        i_id_use_rs1 = 1'b0;
  logic        i_id_use_rs2 = 1'b0;
  logic [4:0]  i_id_rd = '0;
  logic        i_id_reg_wen = 1'b0;
  logic        i_id_mem_read = 1'b0;
  logic        i_ex_redirect = 1'b0;
  logic        i_mem_busy = 1'b0;
  logic        o_stall_if, o_stall_id, o_flush_id, o_bubble_ex;
  logic        o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1;
  logic        o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2;
  logic [31:0] o_stall_cnt;

  int passed = 0;
  int total  = 0;

  hzd_unit #(.CNT_W(32), .REG_AW(5)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_id_valid         (i_id_valid),
    .i_id_rs1           (i_id_rs1),
    .i_id_rs2           (i_id_rs2),
    .i_id_use_rs1       (i_id_use_rs1),
    .i_id_use_rs2       (i_id_use_rs2),
    .i_id_rd            (i_id_rd),
    .i_id_reg_wen       (i_id_reg_wen),
    .i_id_mem_read      (i_id_mem_read),
    .i_ex_redirect      (i_ex_redirect),
    .i_mem_busy         (i_mem_busy),
    .o_stall_if         (o_stall_if),
    .o_stall_id         (o_stall_id),
    .o_flush_id         (o_flush_id),
    .o_bubble_ex        (o_bubble_ex),
    .o_frwd_alu_op1     (o_frwd_alu_op1),
    .o_frwd_mem_alu_op1 (o_frwd_mem_alu_op1),
    .o_frwd_mem_op1     (o_frwd_mem_op1),
    .o_frwd_alu_op2     (o_frwd_alu_op2),
    .o_frwd_mem_alu_op2 (o_frwd_mem_alu_op2),
    .o_frwd_mem_op2     (o_frwd_mem_op2),
    .o_stall_cnt        (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // {stall_if, stall_id, flush_id, bubble_ex}
  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, o_stall_if, o_stall_id, o_flush_id, o_bubble_ex}, {28'd0, exp});
  endtask

  // {alu1, mem_alu1, mem1, alu2, mem_alu2, mem2}
  task automatic chk_frwd(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1,
              o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2}, {26'd0, exp});
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic ld);
    i_id_valid    = v;
    i_id_rs1      = rs1;
    i_id_use_rs1  = u1;
    i_id_rs2      = rs2;
    i_id_use_rs2  = u2;
    i_id_rd       = rd;
    i_id_reg_wen  = wen;
    i_id_mem_read = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // reset
    step();
    chk_ctrl("reset_ctrl", 4'b0000);
    chk_frwd("reset_frwd", 6'b000000);
    chk("reset_cnt", o_stall_cnt, 32'd0);
    i_rst = 1'b0;

    // back-to-back ALU dependency: add x5 ; sub rs1=x5
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
    #1 chk_ctrl("add_x5_ctrl", 4'b0000);
    step();
    set_id(1, 5'd5, 1, 5'd3, 1, 5'd9, 1, 0);
    #1 chk_ctrl("sub_dep1_ctrl", 4'b0000);
    step();
    chk_frwd("sub_dep1_frwd", 6'b100000);
    nop();
    step();
    chk_frwd("nop_frwd", 6'b000000);

    // distance-2: add x6 ; nop ; or rs2=x6
    set_id(1, 5'd2, 1, 5'd3, 1, 5'd6, 1, 0);
    step();
    nop();
    step();
    set_id(1, 5'd1, 1, 5'd6, 1, 5'd10, 1, 0);
    #1 chk_ctrl("or_dep2_ctrl", 4'b0000);
    step();
    chk_frwd("or_dep2_frwd", 6'b000010);
    nop();
    step();

    // load-use: lw x7 ; add rs1=x7
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1);
    step();
    set_id(1, 5'd7, 1, 5'd0, 1, 5'd11, 1, 0);
    #1 chk_ctrl("lu_stall_ctrl", 4'b1101);
    chk("lu_cnt_before", o_stall_cnt, 32'd0);
    step();
    chk("lu_cnt_after", o_stall_cnt, 32'd1);
    chk_frwd("lu_bubble_frwd", 6'b000000);
    chk_ctrl("lu_release_ctrl", 4'b0000);
    step();
    chk_frwd("lu_mem_frwd", 6'b001000);
    chk("lu_cnt_hold", o_stall_cnt, 32'd1);
    nop();
    step();

    // nearest producer wins: addi x8 ; addi x8 ; add rs1=x8
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd8, 1, 0);
    step();
    set_id(1, 5'd0, 1, 5'd0, 0, 5'd8, 1, 0);
    step();
    set_id(1, 5'd8, 1, 5'd1, 1, 5'd12, 1, 0);
    step();
    chk_frwd("nearest_frwd", 6'b100000);
    // x0 writer then x0 consumer
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0);
    step();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd13, 1, 0);
    step();
    chk_frwd("x0_frwd", 6'b000000);
    nop();
    step();

    // redirect overrides load-use
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd12, 1, 1);
    step();
    set_id(1, 5'd12, 1, 5'd0, 0, 5'd14, 1, 0);
    i_ex_redirect = 1'b1;
    #1 chk_ctrl("redir_ctrl", 4'b0011);
    step();
    chk("redir_cnt", o_stall_cnt, 32'd1);
    chk_frwd("redir_frwd", 6'b000000);
    i_ex_redirect = 1'b0;
    nop();
    step();

    // memory freeze during a distance-1 dependency: add x13 ; lw x14 rs1=x13 ; add rs1=x14
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd13, 1, 0);
    step();
    set_id(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 1);
    step();
    chk_frwd("frz_pre_frwd", 6'b100000);
    set_id(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0);
    i_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctrl("frz_ctrl", 4'b1100);
      chk_frwd("frz_frwd", 6'b100000);
      chk("frz_cnt", o_stall_cnt, 32'd1);
      step();
    end
    i_mem_busy = 1'b0;
    #1 chk_ctrl("frz_exit_lu_ctrl", 4'b1101);
    step();
    chk("frz_exit_cnt", o_stall_cnt, 32'd2);

    // reset asserted mid-freeze
    i_mem_busy = 1'b1;
    #1 chk_ctrl("frz2_ctrl", 4'b1100);
    i_rst = 1'b1;
    #1 chk_ctrl("rst_frz_ctrl", 4'b0000);
    chk_frwd("rst_frz_frwd", 6'b000000);
    chk("rst_frz_cnt", o_stall_cnt, 32'd0);
    step();
    i_rst = 1'b0;
    i_mem_busy = 1'b0;
    set_id(1, 5'd14, 1, 5'd13, 1, 5'd16, 1, 0);
    #1 chk_ctrl("post_rst_ctrl", 4'b0000);
    step();
    chk_frwd("post_rst_frwd", 6'b000000);
    chk("post_rst_cnt", o_stall_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hzd_unit.md
Name: hzd_unit

Overview:
- Hazard detection and forwarding-control unit in the ID stage of the 5-stage RV32I pipeline.
- Keeps a shadow of the destination registers in flight (EX, MEM, WB) and decides load-use stalls and redirect flushes.
- Computes the six forwarding selects for the instruction leaving ID and registers them, so they arrive at the EX-stage operand forwarding mux aligned with that instruction.
- Counts load-use stall cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the load-use stall counter.
- REG_AW, 5, register index width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_rs1  in  REG_AW  rs1 index of the ID instruction.
- i_id_rs2  in  REG_AW  rs2 index of the ID instruction.
- i_id_use_rs1  in  1  ID instruction reads rs1.
- i_id_use_rs2  in  1  ID instruction reads rs2.
- i_id_rd  in  REG_AW  rd index of the ID instruction.
- i_id_reg_wen  in  1  ID instruction writes rd.
- i_id_mem_read  in  1  ID instruction is a load.
- i_ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- i_mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- o_stall_if  out  1  hold PC.
- o_stall_id  out  1  hold the IF/ID register.
- o_flush_id  out  1  invalidate the IF/ID register.
- o_bubble_ex  out  1  load a NOP into the ID/EX register.
- o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1  out  1 each  registered op1 selects, valid in EX.
- o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2  out  1 each  registered op2 selects, valid in EX.
- o_stall_cnt  out  CNT_W  load-use stall cycles since reset.

Behaviour:
- **Shadow slots.** Three slots: EX, MEM, WB. Each slot holds {valid, rd, wen, load}.
- **"Producer" definition.** A slot counts as a producer only when valid & wen & rd != 0.
- **Reset.** All slots are invalid. All outputs are 0, and o_stall_cnt is 0.
- **Load-use condition (lu).** lu = i_id_valid & EX slot is a producer & EX.load & ((use_rs1 & rs1==EX.rd) | (use_rs2 & rs2==EX.rd)).
- **Combinational controls, priority order:**
  - i_mem_busy: o_stall_if = o_stall_id = 1; flush = 0, bubble = 0; all state holds, including the frwd registers and the counter.
  - else i_ex_redirect: o_flush_id = 1, o_bubble_ex = 1, stall = 0. lu is ignored because the ID instruction is squashed.
  - else lu: o_stall_if = o_stall_id = 1, o_bubble_ex = 1.
  - else: all controls are 0.
- **Slot advance** (every edge unless i_mem_busy):
  - WB <= MEM, then MEM <= EX.
  - EX <= ID fields when there is no bubble; otherwise EX goes invalid.
- **Forwarding decision** for the ID instruction, registered into the frwd outputs on the same edge it enters EX. Evaluate per operand, only when use_rsN & rsN != 0.
  - The comparison targets the slots the producers will occupy when the consumer is in EX. That means the current EX slot (becoming MEM) and the current MEM slot (becoming WB).
  - Current EX producer matching, non-load → frwd_alu = 1.
  - Otherwise, current MEM producer matching: non-load → frwd_mem_alu = 1; load → frwd_mem = 1.
  - The nearest producer wins. At most one select per operand is 1.
  - A current EX producer matching and being a load cannot occur here, because lu inserts a bubble.
  - On bubble, all six frwd registers load 0.
- **Counter.** o_stall_cnt increments on each edge where lu & !i_ex_redirect & !i_mem_busy. It wraps modulo 2^CNT_W.
- **Reset mid-stall.** All state clears immediately and asynchronously. The first instruction after reset sees no producers.
- **Latency.** Control outputs are combinational, same cycle. Forwarding selects have one cycle of latency: decided in ID, visible in EX.

Decomposition:
- Package hzd_pkg:
  - slot struct typedef {valid, rd, wen, load}.
  - REG_AW constant.
  - X0 index constant.
- Sub-module hzd_fsel: purely combinational, instantiated twice, once for op1 and once for op2. Inputs are rsN, use_rsN and the EX/MEM slots. Output is the 3-bit one-hot select.

Test Plan:
- **Back-to-back ALU dependency.** add x5 in ID; next cycle sub rs1=x5 in ID → following cycle o_frwd_alu_op1 = 1, other op1 selects 0, no stall.
- **Distance-2 dependency.** add x6, nop, then or rs2=x6 → o_frwd_mem_alu_op2 = 1 in EX of the or.
- **Load-use.** lw x7, then add rs1=x7:
  - Cycle n: o_stall_if = o_stall_id = o_bubble_ex = 1, and o_stall_cnt goes 0 → 1.
  - Cycle n+1: no stall.
  - When add is in EX: o_frwd_mem_op1 = 1.
- **Nearest-producer wins.** addi x8, addi x8, add rs1=x8 → o_frwd_alu_op1 = 1 only; x0 writer with rs1=x0 consumer → all selects 0.
- **Redirect over load-use.** i_ex_redirect = 1 while lu is true → o_flush_id = 1, o_bubble_ex = 1, stall = 0, counter unchanged.
- **Memory freeze.** i_mem_busy held 3 cycles during a distance-1 dependency → frwd outputs, slots and counter are stable, o_stall_if = 1 throughout. Assert i_rst mid-freeze → all outputs 0 immediately.
